// File: rtl/rggen_indirect_register_array.sv
// rggen_indirect_register_array
//   One bus address fronting an array of ENTRIES data words. The word is
//   picked by i_indirect_index - INDEX_BASE. Writes finish in one cycle and
//   honour byte strobes. Reads finish READ_LATENCY cycles after they are
//   accepted, sequenced by a small IDLE/BUSY wait-state FSM.
//
//   Optional feature macro: RGGEN_INDIRECT_ARRAY_AUTO_INCREMENT_EN
//     When defined, o_index_increment pulses for one cycle after every
//     access that completes with OKAY. When undefined, it is tied low.
//
// Ports
//   i_clk, i_rst_n          clock, asynchronous active-low reset
//   i_register_valid        request valid, held until ready
//   i_register_access       bit0: 1 = write, 0 = read
//   i_register_address      byte address
//   i_register_write_data   write data
//   i_register_strobe       byte enables
//   i_indirect_index        entry select
//   o_register_active       request targets this register (or a read is in flight)
//   o_register_ready        access completes this cycle
//   o_register_status       2'b00 OKAY, 2'b10 SLVERR
//   o_register_read_data    read data, valid with ready, 0 otherwise
//   o_entry_values          all entries, entry 0 in the LSBs
//   o_index_increment       one-cycle pulse after an OKAY access (optional)
module rggen_indirect_register_array #(
    parameter bit                       READABLE       = 1'b1,
    parameter bit                       WRITABLE       = 1'b1,
    parameter int unsigned              ADDRESS_WIDTH  = 8,
    parameter logic [ADDRESS_WIDTH-1:0] OFFSET_ADDRESS = '0,
    parameter int unsigned              BUS_WIDTH      = 32,
    parameter int unsigned              INDEX_WIDTH    = 4,
    parameter int unsigned              INDEX_BASE     = 0,
    parameter int unsigned              ENTRIES        = 4,
    parameter int unsigned              READ_LATENCY   = 1,
    parameter logic [BUS_WIDTH-1:0]     INITIAL_VALUE  = '0
) (
    input  logic                           i_clk,
    input  logic                           i_rst_n,
    input  logic                           i_register_valid,
    input  logic [1:0]                     i_register_access,
    input  logic [ADDRESS_WIDTH-1:0]       i_register_address,
    input  logic [BUS_WIDTH-1:0]           i_register_write_data,
    input  logic [BUS_WIDTH/8-1:0]         i_register_strobe,
    input  logic [INDEX_WIDTH-1:0]         i_indirect_index,
    output logic                           o_register_active,
    output logic                           o_register_ready,
    output logic [1:0]                     o_register_status,
    output logic [BUS_WIDTH-1:0]           o_register_read_data,
    output logic [ENTRIES*BUS_WIDTH-1:0]   o_entry_values,
    output logic                           o_index_increment
);

    localparam int unsigned STRB_W   = BUS_WIDTH / 8;
    localparam int unsigned ADDR_LSB = (STRB_W > 1) ? $clog2(STRB_W) : 0;
    localparam int unsigned ENTRY_W  = INDEX_WIDTH + 1;
    localparam int unsigned CNT_W    = 3;

    // Byte-lane bits of the address are don't-care for the match.
    localparam logic [ADDRESS_WIDTH-1:0] ADDR_MASK =
        ~((ADDRESS_WIDTH'(1) << ADDR_LSB) - ADDRESS_WIDTH'(1));
    localparam logic [ENTRY_W:0]     BASE_EXT = (ENTRY_W + 1)'(INDEX_BASE);
    localparam logic [ENTRY_W-1:0]   NUM      = ENTRY_W'(ENTRIES);
    localparam logic [CNT_W-1:0]     LAT      = CNT_W'(READ_LATENCY);
    localparam logic [1:0]           STATUS_OKAY   = 2'b00;
    localparam logic [1:0]           STATUS_SLVERR = 2'b10;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [ENTRY_W-1:0]     entry_q, entry_d;
    logic [BUS_WIDTH-1:0]   rdata_q, rdata_d;
    logic [BUS_WIDTH-1:0]   entries_q [ENTRIES];

    logic                   addr_match_c;
    logic [ENTRY_W:0]       index_diff_c;
    logic [ENTRY_W-1:0]     entry_num_c;
    logic                   index_match_c;
    logic                   hit_c;
    logic                   is_write_c;
    logic [BUS_WIDTH-1:0]   sel_data_c;
    logic [BUS_WIDTH-1:0]   lat_data_c;
    logic                   ready_c;
    logic [1:0]             status_c;
    logic [BUS_WIDTH-1:0]   read_data_c;
    logic                   wr_en_c;
    logic                   unused_access;

    assign unused_access = i_register_access[1];

    // Address and index decode; the extra diff bit is the borrow of index < base.
    assign addr_match_c  = (i_register_address & ADDR_MASK) == (OFFSET_ADDRESS & ADDR_MASK);
    assign index_diff_c  = (ENTRY_W + 1)'(i_indirect_index) - BASE_EXT;
    assign entry_num_c   = index_diff_c[ENTRY_W-1:0];
    assign index_match_c = !index_diff_c[ENTRY_W] && (entry_num_c < NUM);
    assign hit_c         = i_register_valid && addr_match_c && index_match_c;
    assign is_write_c    = i_register_access[0];

    // Entry muxes: live index for same-cycle paths, latched index for delayed reads.
    always_comb begin
        sel_data_c = '0;
        lat_data_c = '0;
        for (int i = 0; i < ENTRIES; i++) begin
            if (entry_num_c == ENTRY_W'(i)) sel_data_c = entries_q[i];
            if (entry_q == ENTRY_W'(i))     lat_data_c = entries_q[i];
        end
    end

    // Read wait-state FSM and bus response.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        entry_d     = entry_q;
        rdata_d     = rdata_q;
        ready_c     = 1'b0;
        status_c    = STATUS_OKAY;
        read_data_c = '0;
        wr_en_c     = 1'b0;
        if (state_q == BUSY) begin
            if (cnt_q == LAT) begin
                ready_c     = 1'b1;
                read_data_c = rdata_q;
                state_d     = IDLE;
                cnt_d       = '0;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
                if (cnt_d == LAT) rdata_d = lat_data_c;
            end
        end else if (hit_c) begin
            if (is_write_c) begin
                ready_c = 1'b1;
                if (WRITABLE) wr_en_c  = 1'b1;
                else          status_c = STATUS_SLVERR;
            end else if (!READABLE) begin
                ready_c  = 1'b1;
                status_c = STATUS_SLVERR;
            end else if (LAT == '0) begin
                ready_c     = 1'b1;
                read_data_c = sel_data_c;
            end else begin
                state_d = BUSY;
                cnt_d   = CNT_W'(1);
                entry_d = entry_num_c;
                if (LAT == CNT_W'(1)) rdata_d = sel_data_c;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            entry_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            entry_q <= entry_d;
            rdata_q <= rdata_d;
        end
    end

    // Entry storage with per-byte write enables.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            for (int i = 0; i < ENTRIES; i++) entries_q[i] <= INITIAL_VALUE;
        end else if (wr_en_c) begin
            for (int i = 0; i < ENTRIES; i++) begin
                for (int b = 0; b < STRB_W; b++) begin
                    if ((entry_num_c == ENTRY_W'(i)) && i_register_strobe[b]) begin
                        entries_q[i][8*b+:8] <= i_register_write_data[8*b+:8];
                    end
                end
            end
        end
    end

    for (genvar g = 0; g < ENTRIES; g++) begin : g_entry_out
        assign o_entry_values[g*BUS_WIDTH+:BUS_WIDTH] = entries_q[g];
    end

    assign o_register_active    = hit_c || (state_q == BUSY);
    assign o_register_ready     = ready_c;
    assign o_register_status    = status_c;
    assign o_register_read_data = read_data_c;

`ifdef RGGEN_INDIRECT_ARRAY_AUTO_INCREMENT_EN
    logic inc_q, inc_d;

    // Pulse once after an OKAY completion so the index owner can advance.
    assign inc_d = ready_c && (status_c == STATUS_OKAY);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) inc_q <= 1'b0;
        else          inc_q <= inc_d;
    end

    assign o_index_increment = inc_q;
`else
    assign o_index_increment = 1'b0;
`endif

endmodule

// File: tb/tb_rggen_indirect_register_array.sv
// Randomized bench for rggen_indirect_register_array with a behavioural
// array model. A second instance with WRITABLE=0 shares the bus inputs.
module tb_rggen_indirect_register_array;

    localparam int unsigned AW   = 8;
    localparam int unsigned BW   = 32;
    localparam int unsigned IW   = 4;
    localparam int unsigned BASE = 2;
    localparam int unsigned ENT  = 4;
    localparam int unsigned LAT  = 2;

`ifdef RGGEN_INDIRECT_ARRAY_AUTO_INCREMENT_EN
    localparam bit INC_EN = 1'b1;
`else
    localparam bit INC_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              valid = 1'b0;
    logic [1:0]        access = 2'b00;
    logic [AW-1:0]     address = '0;
    logic [BW-1:0]     wdata = '0;
    logic [BW/8-1:0]   strobe = '0;
    logic [IW-1:0]     index = '0;

    logic              active, ready, incr;
    logic [1:0]        status;
    logic [BW-1:0]     rdata;
    logic [ENT*BW-1:0] entry_values;

    logic              ro_active, ro_ready, ro_incr;
    logic [1:0]        ro_status;
    logic [BW-1:0]     ro_rdata;
    logic [ENT*BW-1:0] ro_entry_values;

    int                checks = 0;
    int                errors = 0;
    logic [BW-1:0]     model [ENT];

    always #5 clk = ~clk;

    rggen_indirect_register_array #(
        .READABLE(1'b1), .WRITABLE(1'b1), .ADDRESS_WIDTH(AW), .OFFSET_ADDRESS(8'h10),
        .BUS_WIDTH(BW), .INDEX_WIDTH(IW), .INDEX_BASE(BASE), .ENTRIES(ENT),
        .READ_LATENCY(LAT), .INITIAL_VALUE(32'h0)
    ) u_dut (
        .i_clk(clk), .i_rst_n(rst_n), .i_register_valid(valid),
        .i_register_access(access), .i_register_address(address),
        .i_register_write_data(wdata), .i_register_strobe(strobe),
        .i_indirect_index(index), .o_register_active(active),
        .o_register_ready(ready), .o_register_status(status),
        .o_register_read_data(rdata), .o_entry_values(entry_values),
        .o_index_increment(incr)
    );

    rggen_indirect_register_array #(
        .READABLE(1'b1), .WRITABLE(1'b0), .ADDRESS_WIDTH(AW), .OFFSET_ADDRESS(8'h10),
        .BUS_WIDTH(BW), .INDEX_WIDTH(IW), .INDEX_BASE(BASE), .ENTRIES(ENT),
        .READ_LATENCY(LAT), .INITIAL_VALUE(32'h0)
    ) u_dut_ro (
        .i_clk(clk), .i_rst_n(rst_n), .i_register_valid(valid),
        .i_register_access(access), .i_register_address(address),
        .i_register_write_data(wdata), .i_register_strobe(strobe),
        .i_indirect_index(index), .o_register_active(ro_active),
        .o_register_ready(ro_ready), .o_register_status(ro_status),
        .o_register_read_data(ro_rdata), .o_entry_values(ro_entry_values),
        .o_index_increment(ro_incr)
    );

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [127:0] model_vec();
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < ENT; i++) v[i*BW+:BW] = model[i];
        return v;
    endfunction

    function automatic bit is_hit(input int idx, input logic [AW-1:0] addr);
        return (idx >= BASE) && (idx < BASE + ENT) && (addr[AW-1:2] == 6'h04);
    endfunction

    task automatic do_write(input int idx, input logic [AW-1:0] addr,
                            input logic [BW-1:0] data, input logic [3:0] strb);
        bit hit;
        hit = is_hit(idx, addr);
        @(negedge clk);
        valid = 1'b1; access = 2'b01; address = addr; wdata = data;
        strobe = strb; index = IW'(idx);
        #1;
        check_eq("wr_active", 128'(active), 128'(hit));
        check_eq("wr_ready", 128'(ready), 128'(hit));
        check_eq("wr_rdata", 128'(rdata), 128'(0));
        if (hit) check_eq("wr_status", 128'(status), 128'(2'b00));
        check_eq("ro_wr_ready", 128'(ro_ready), 128'(hit));
        if (hit) check_eq("ro_wr_status", 128'(ro_status), 128'(2'b10));
        @(posedge clk);
        #1 valid = 1'b0; access = 2'b00;
        if (hit) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model[idx-BASE][8*b+:8] = data[8*b+:8];
        end
        @(negedge clk);
        check_eq("wr_entries", entry_values, model_vec());
        check_eq("ro_entries", ro_entry_values, 128'(0));
        check_eq("wr_incr", 128'(incr), 128'(INC_EN && hit));
        check_eq("ro_wr_incr", 128'(ro_incr), 128'(0));
    endtask

    task automatic do_read(input int idx, input logic [AW-1:0] addr);
        bit hit;
        int k;
        logic [BW-1:0] exp;
        hit = is_hit(idx, addr);
        @(negedge clk);
        valid = 1'b1; access = 2'b00; address = addr; index = IW'(idx);
        #1;
        check_eq("rd_active", 128'(active), 128'(hit));
        check_eq("rd_ready_accept", 128'(ready), 128'(0));
        check_eq("rd_rdata_accept", 128'(rdata), 128'(0));
        if (!hit) begin
            @(posedge clk);
            #1 valid = 1'b0;
            @(negedge clk);
            check_eq("rd_miss_ready", 128'(ready), 128'(0));
            return;
        end
        exp = model[idx-BASE];
        k = 0;
        do begin
            @(posedge clk);
            #1;
            index = IW'($urandom_range(0, 15));
            address = AW'($urandom);
            @(negedge clk);
            k++;
            check_eq("rd_active_busy", 128'(active), 128'(1));
        end while (!ready && k < 8);
        check_eq("rd_latency", 128'(k), 128'(LAT));
        check_eq("rd_data", 128'(rdata), 128'(exp));
        check_eq("rd_status", 128'(status), 128'(2'b00));
        check_eq("ro_rd_ready", 128'(ro_ready), 128'(1));
        check_eq("ro_rd_data", 128'(ro_rdata), 128'(0));
        @(posedge clk);
        #1 valid = 1'b0;
        @(negedge clk);
        check_eq("rd_ready_once", 128'(ready), 128'(0));
        check_eq("rd_incr", 128'(incr), 128'(INC_EN));
        check_eq("ro_rd_incr", 128'(ro_incr), 128'(INC_EN));
    endtask

    initial begin
        for (int i = 0; i < ENT; i++) model[i] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_eq("rst_entries", entry_values, model_vec());
        check_eq("rst_ready", 128'(ready), 128'(0));
        check_eq("rst_status", 128'(status), 128'(0));
        check_eq("rst_rdata", 128'(rdata), 128'(0));
        check_eq("rst_incr", 128'(incr), 128'(0));
        check_eq("rst_active", 128'(active), 128'(0));

        // Directed cases
        do_read(2, 8'h10);
        do_write(3, 8'h10, 32'hDEAD_BEEF, 4'b0101);
        check_eq("t2_entry1", 128'(entry_values[63:32]), 128'(32'h00AD_00EF));
        do_read(3, 8'h13);
        do_write(1, 8'h10, 32'hFFFF_FFFF, 4'hF);
        do_write(6, 8'h10, 32'hFFFF_FFFF, 4'hF);
        do_write(5, 8'h10, 32'hCAFE_F00D, 4'hF);
        do_read(5, 8'h10);
        do_read(6, 8'h10);
        do_write(2, 8'h14, 32'h5555_5555, 4'hF);
        do_write(2, 8'h10, 32'h1234_5678, 4'hF);

        // Random traffic
        for (int n = 0; n < 80; n++) begin
            int idx;
            logic [AW-1:0] addr;
            idx = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 15))
                                              : int'($urandom_range(BASE, BASE + ENT - 1));
            addr = ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'(8'h10 | $urandom_range(0, 3));
            if ($urandom_range(0, 1) == 1) do_write(idx, addr, $urandom, 4'($urandom));
            else                           do_read(idx, addr);
        end

        // Reset during an in-flight read
        do_write(4, 8'h10, 32'hA5A5_0001, 4'hF);
        @(negedge clk);
        valid = 1'b1; access = 2'b00; address = 8'h10; index = 4'd4;
        @(posedge clk);
        #1 index = 4'd2;
        @(negedge clk);
        rst_n = 1'b0; valid = 1'b0;
        for (int i = 0; i < ENT; i++) model[i] = '0;
        #1;
        check_eq("mid_rst_ready", 128'(ready), 128'(0));
        check_eq("mid_rst_entries", entry_values, model_vec());
        check_eq("mid_rst_active", 128'(active), 128'(0));
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_eq("post_rst_ready", 128'(ready), 128'(0));
        end
        do_read(4, 8'h10);
        do_read(2, 8'h10);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/rggen_indirect_register_array.md
Name: rggen_indirect_register_array

Overview:
Indirect register whose single bus address fronts an internal array of ENTRIES data words. The entry is selected by an externally supplied indirect index, offset by INDEX_BASE. Reads have a configurable fixed latency through a small wait-state FSM; writes complete in one cycle with byte strobes. The block sits in the generated register block beside ordinary and single-entry indirect registers, on the same register bus.

Parameters:
READABLE, 1'b1, reads permitted
WRITABLE, 1'b1, writes permitted
ADDRESS_WIDTH, 8, register bus address width
OFFSET_ADDRESS, 0, byte address of the register
BUS_WIDTH, 32, bus data width; data word width equals BUS_WIDTH
INDEX_WIDTH, 4, indirect index width
INDEX_BASE, 0, index value mapping to entry 0
ENTRIES, 4, number of entries (1..2**INDEX_WIDTH)
READ_LATENCY, 1, cycles from accepted read to ready (0..7)
INITIAL_VALUE, 0, reset value of every entry (BUS_WIDTH bits)

Ports:
i_clk  in  1  clock
i_rst_n  in  1  asynchronous active-low reset
i_register_valid  in  1  bus request valid, held until ready
i_register_access  in  2  bit0=1 write, bit0=0 read
i_register_address  in  ADDRESS_WIDTH  byte address
i_register_write_data  in  BUS_WIDTH  write data
i_register_strobe  in  BUS_WIDTH/8  byte enables
i_indirect_index  in  INDEX_WIDTH  entry select
o_register_active  out  1  request targets this register
o_register_ready  out  1  access complete this cycle
o_register_status  out  2  00 OKAY, 10 SLVERR
o_register_read_data  out  BUS_WIDTH  read data, valid with ready
o_entry_values  out  ENTRIES*BUS_WIDTH  all entries, entry 0 in LSBs
o_index_increment  out  1  see Optional Feature

Behaviour:
- Clock and reset: single clock i_clk; asynchronous active-low reset i_rst_n.
- Reset state: all entries = INITIAL_VALUE; FSM IDLE; latency counter 0; ready 0; read_data 0; status 00; o_index_increment 0.
- Address match: address bits above log2(BUS_WIDTH/8) equal those of OFFSET_ADDRESS; low bits ignored.
- Index match: INDEX_BASE <= index < INDEX_BASE+ENTRIES. Entry number = index - INDEX_BASE, computed in INDEX_WIDTH+1 bits, so there is no wrap.
- o_register_active = valid & address match & index match, or FSM in BUSY.
- Access permission:
  - Write with WRITABLE=0, or read with READABLE=0: ready in the same cycle, status 10, no array change, read_data 0.
- Write (active, permitted):
  - ready combinational in the same cycle, status 00.
  - At that edge, each byte with strobe=1 of the selected entry takes write_data; other bytes hold.
- Read, READ_LATENCY=0: ready in the same cycle, read_data = selected entry, combinational.
- Read, READ_LATENCY>0, FSM:
  - IDLE -> BUSY on active permitted read. Latch the entry number; counter=1.
  - BUSY: counter increments each cycle. When counter==READ_LATENCY, read_data is registered from the latched entry and ready=1 for exactly one cycle, then IDLE.
  - Total: ready appears READ_LATENCY cycles after the accept cycle.
  - Index or address changes during BUSY are ignored.
  - A write to the same entry during BUSY cannot occur (bus holds the request).
- Ready is never asserted for two consecutive cycles on the same read. A new read is accepted in the cycle after ready.
- Reset mid-read: FSM returns to IDLE immediately, no ready issued, entries reinitialised.
- Out-of-range index or address mismatch: active=0, ready=0, read_data=0, and the array is untouched. The default responder handles the access.
- o_entry_values reflects array contents registered, updated at the write edge.

Optional Feature:
- Macro: RGGEN_INDIRECT_ARRAY_AUTO_INCREMENT_EN.
- Defined: o_index_increment pulses high for one cycle, in the cycle after any successful (status 00) access completes. The index-owning register uses it to advance the index. No pulse on SLVERR.
- Undefined: o_index_increment tied 0, no extra logic.

Test Plan:
All tests use BUS_WIDTH=32, OFFSET_ADDRESS=0x10, INDEX_BASE=2, ENTRIES=4, READ_LATENCY=2, INITIAL_VALUE=0.
1. Reset -> read index 2 at 0x10: ready exactly 2 cycles after accept, data 0x0000_0000, status 00; o_entry_values all 0.
2. Write 0xDEAD_BEEF strobe 4'b0101 at index 3 -> same-cycle ready, status 00; entry1 = 0x00AD_00EF; read index 3 returns 0x00AD_00EF.
3. Index 1 and index 6 with valid at 0x10 -> active=0, ready=0, entries unchanged; index 5 -> active=1 (entry 3).
4. Read index 4 accepted, index changed to 2 and i_rst_n pulsed low one cycle later -> no ready; all entries 0; FSM IDLE.
5. Instance with WRITABLE=0: write 0x1234_5678 -> ready same cycle, status 10, entry unchanged.
6. With RGGEN_INDIRECT_ARRAY_AUTO_INCREMENT_EN defined: write at index 2 -> o_index_increment=1 one cycle after ready; SLVERR access -> no pulse. Undefined: output stays 0.
